fwd_hazard_ctrl: RTL and testbench

// - Producer side of the forwarding-mux select path: tracks destination registers of in-flight instructions and

---
 rtl/fwd_hazard_ctrl_pkg.sv | 37 +++
 rtl/fwd_sel_unit.sv | 28 ++
 rtl/fwd_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the forwarding/hazard controller and the EX operand muxes.
// The select encoding here is the one the datapath muxes decode, so both sides import it.
package fwd_hazard_ctrl_pkg;

  localparam int REG_W       = 5;
  localparam int SEL_W       = 2;
  localparam int STALL_CNT_W = 32;

  typedef logic [REG_W-1:0] reg_t;
  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_RF   = 2'b00;
  localparam sel_t SEL_MEM  = 2'b01;
  localparam sel_t SEL_ALU  = 2'b10;
  localparam reg_t REG_ZERO = '0;

  // Destination half of a pipeline slot: all that later stages need for forwarding.
  typedef struct packed {
    logic valid;
    logic wr_en;
    reg_t wr_reg;
    logic is_load;
  } dst_t;

  typedef struct packed {
    dst_t dst;
    logic use_rs;
    reg_t rs;
    logic use_rt;
    reg_t rt;
  } slot_t;

  function automatic logic slot_match(input dst_t s, input reg_t r);
    return s.valid & s.wr_en & (s.wr_reg == r) & (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Forward-select decision for one EX operand: youngest matching producer wins,
// a load still in EX/MEM cannot supply its data and is reported instead.
module fwd_sel_unit
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic use_i,
  input  reg_t reg_i,
  input  dst_t mem_i,
  input  dst_t wb_i,
  output sel_t sel_o,
  output logic load_hit_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the ifs can infer a latch.
    sel_o      = SEL_RF;
    load_hit_o = 1'b0;
    if (use_i) begin
      if (slot_match(mem_i, reg_i)) begin
        if (mem_i.is_load) load_hit_o = 1'b1;
        else               sel_o      = SEL_ALU;
      end else if (slot_match(wb_i, reg_i)) begin
        sel_o = SEL_MEM;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller; shadows the ID/EX, EX/MEM and
// MEM/WB registers so selects and stall are combinational from local state plus ID.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = STALL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  reg_t             id_rs,
  input  reg_t             id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  reg_t             id_wr_reg,
  input  logic             id_is_load,
  output sel_t             fwd_a,
  output sel_t             fwd_b,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             hazard_err
);

  // Source fields only matter while an instruction sits in EX, so MEM/WB keep the destination half.
  slot_t            ex_q, ex_d, id_slot;
  dst_t             mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hazard_err_q, hazard_err_d;
  logic             load_hit_a, load_hit_b;
  logic             ex_load_dst;

  assign id_slot = '{
    dst:    '{valid: id_valid, wr_en: id_wr_en, wr_reg: id_wr_reg, is_load: id_is_load},
    use_rs: id_use_rs,
    rs:     id_rs,
    use_rt: id_use_rt,
    rt:     id_rt
  };

  fwd_sel_unit u_sel_a (
    .use_i      (ex_q.use_rs),
    .reg_i      (ex_q.rs),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (fwd_a),
    .load_hit_o (load_hit_a)
  );

  fwd_sel_unit u_sel_b (
    .use_i      (ex_q.use_rt),
    .reg_i      (ex_q.rt),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (fwd_b),
    .load_hit_o (load_hit_b)
  );

  assign ex_load_dst = ex_q.dst.valid & ex_q.dst.is_load & ex_q.dst.wr_en &
                       (ex_q.dst.wr_reg != REG_ZERO);

  // A taken branch kills the ID instruction anyway, so it overrides the stall.
  assign stall  = id_valid & ex_load_dst & !flush &
                  ((id_use_rs & (ex_q.dst.wr_reg == id_rs)) |
                   (id_use_rt & (ex_q.dst.wr_reg == id_rt)));
  assign bubble = stall | flush;

  always_comb begin
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    stall_cnt_d  = stall_cnt_q;
    hazard_err_d = hazard_err_q | (ex_q.dst.valid & (load_hit_a | load_hit_b));
    if (!hold) begin
      wb_d           = mem_q;
      mem_d          = ex_q.dst;
      ex_d           = id_slot;
      ex_d.dst.valid = id_valid & !flush & !stall;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only the valid bits are functionally required; payloads are cleared too so post-reset state is fully defined.
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      stall_cnt_q  <= '0;
      hazard_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every slot samples the pre-edge value of its neighbour.
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      stall_cnt_q  <= stall_cnt_d;
      hazard_err_q <= hazard_err_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign hazard_err = hazard_err_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench: directed MIPS-style sequences then randomized traffic, checked
// against an instruction-level pipeline model.
module tb_fwd_hazard_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, hold, flush;
  logic          id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load;
  logic [4:0]    id_rs, id_rt, id_wr_reg;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall, bubble, hazard_err;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .id_wr_en   (id_wr_en),
    .id_wr_reg  (id_wr_reg),
    .id_is_load (id_is_load),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stall      (stall),
    .bubble     (bubble),
    .stall_cnt  (stall_cnt),
    .hazard_err (hazard_err)
  );

  typedef struct {
    bit       valid, wr_en, load, use_rs, use_rt;
    bit [4:0] wr, rs, rt;
  } instr_t;

  typedef struct {
    int fa, fb, st, bu, he, cnt, cyc;
  } exp_t;

  exp_t   sb[$];
  instr_t pipe[3];   // 0 = EX, 1 = MEM, 2 = WB
  int     m_cnt;
  bit     m_herr;
  bit     known;
  int     checks, failures, cyc;
  instr_t cur_id;
  bit     cur_flush, cur_hold, cur_reset, cur_stall, cur_hz;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic instr_t mk(bit v, bit we, int wr, int rs, bit urs, int rt, bit urt, bit ld);
    instr_t i;
    i.valid = v;  i.wr_en = we;  i.wr = 5'(wr);  i.load = ld;
    i.rs = 5'(rs); i.use_rs = urs; i.rt = 5'(rt); i.use_rt = urt;
    return i;
  endfunction

  function automatic bit writes(int s, bit [4:0] r);
    return pipe[s].valid && pipe[s].wr_en && pipe[s].wr == r && r != 0;
  endfunction

  // Where an EX operand must come from: the youngest older instruction writing it.
  function automatic int sel_for(bit use_r, bit [4:0] r, output bit hz);
    hz = 1'b0;
    if (!use_r) return 0;
    if (writes(1, r)) begin
      if (pipe[1].load) begin hz = 1'b1; return 0; end
      return 2;
    end
    if (writes(2, r)) return 1;
    return 0;
  endfunction

  task automatic compute_expect();
    exp_t e;
    bit   hza, hzb;
    instr_t ex = pipe[0];
    cur_stall = cur_id.valid && ex.valid && ex.load && ex.wr_en && ex.wr != 0 && !cur_flush &&
                ((cur_id.use_rs && ex.wr == cur_id.rs) || (cur_id.use_rt && ex.wr == cur_id.rt));
    e.fa  = sel_for(ex.use_rs, ex.rs, hza);
    e.fb  = sel_for(ex.use_rt, ex.rt, hzb);
    cur_hz = ex.valid && (hza || hzb);
    e.st  = int'(cur_stall);
    e.bu  = int'(cur_stall || cur_flush);
    e.he  = int'(m_herr);
    e.cnt = m_cnt;
    e.cyc = cyc;
    if (known) sb.push_back(e);
  endtask

  task automatic drive(input instr_t id, input bit fl, input bit hd, input bit rst);
    @(negedge clk);
    id_valid = id.valid; id_wr_en = id.wr_en; id_wr_reg = id.wr; id_is_load = id.load;
    id_rs = id.rs; id_use_rs = id.use_rs; id_rt = id.rt; id_use_rt = id.use_rt;
    flush = fl; hold = hd; reset = rst;
    cur_id = id; cur_flush = fl; cur_hold = hd; cur_reset = rst;
    compute_expect();
  endtask

  task automatic advance();
    @(posedge clk);
    if (cur_reset) begin
      for (int i = 0; i < 3; i++) pipe[i].valid = 1'b0;
      m_cnt  = 0;
      m_herr = 1'b0;
      known  = 1'b1;
    end else begin
      if (cur_hz) m_herr = 1'b1;
      if (!cur_hold) begin
        if (cur_stall && m_cnt < CMAX) m_cnt++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = cur_id;
        pipe[0].valid = cur_id.valid && !cur_flush && !cur_stall;
      end
    end
    cyc++;
  endtask

  task automatic step(input instr_t id, input bit fl = 0, input bit hd = 0, input bit rst = 0);
    drive(id, fl, hd, rst);
    advance();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("fwd_a@%0d", e.cyc),      fwd_a,      e.fa);
        check($sformatf("fwd_b@%0d", e.cyc),      fwd_b,      e.fb);
        check($sformatf("stall@%0d", e.cyc),      stall,      e.st);
        check($sformatf("bubble@%0d", e.cyc),     bubble,     e.bu);
        check($sformatf("stall_cnt@%0d", e.cyc),  stall_cnt,  e.cnt);
        check($sformatf("hazard_err@%0d", e.cyc), hazard_err, e.he);
      end
    end
  end

  initial begin : stimulus
    instr_t nop, add3, lw8, add10, rnd;
    nop   = mk(0, 0, 0, 0, 0, 0, 0, 0);
    add3  = mk(1, 1, 3, 1, 1, 2, 1, 0);
    lw8   = mk(1, 1, 8, 9, 1, 0, 0, 1);
    add10 = mk(1, 1, 10, 8, 1, 8, 1, 0);

    step(nop, 0, 0, 1);
    step(nop, 0, 0, 1);

    // add $3,$1,$2 ; sub $4,$3,$5
    step(add3);
    drive(mk(1, 1, 4, 3, 1, 5, 1, 0), 0, 0, 0); #2 check("raw_no_stall", stall, 0); advance();
    drive(nop, 0, 0, 0); #2
    check("alu_fwd_a", fwd_a, 2); check("alu_fwd_b", fwd_b, 0); check("alu_no_stall", stall, 0);
    advance();
    repeat (3) step(nop);

    // add $3 ; nop ; or $6,$5,$3
    step(add3);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 1, 6, 5, 1, 3, 1, 0));
    drive(nop, 0, 0, 0); #2 check("mem_fwd_b", fwd_b, 1); check("mem_fwd_a", fwd_a, 0); advance();
    repeat (3) step(nop);

    // add $3 ; add $3 ; use $3 -> youngest wins
    step(add3);
    step(mk(1, 1, 3, 4, 1, 4, 1, 0));
    step(mk(1, 1, 7, 3, 1, 0, 0, 0));
    drive(nop, 0, 0, 0); #2 check("youngest_fwd_a", fwd_a, 2); advance();
    repeat (3) step(nop);

    // lw $8,0($9) ; add $10,$8,$8
    step(lw8);
    drive(add10, 0, 0, 0); #2
    check("lu_stall", stall, 1); check("lu_bubble", bubble, 1); check("lu_cnt0", stall_cnt, 0);
    advance();
    drive(add10, 0, 0, 0); #2 check("lu_stall_off", stall, 0); check("lu_cnt1", stall_cnt, 1); advance();
    drive(nop, 0, 0, 0); #2
    check("lu_fwd_a", fwd_a, 1); check("lu_fwd_b", fwd_b, 1); check("lu_no_herr", hazard_err, 0);
    advance();
    repeat (3) step(nop);

    // $0 is never forwarded and never stalls
    step(mk(1, 1, 0, 1, 1, 2, 1, 0));
    step(mk(1, 1, 11, 0, 1, 0, 0, 0));
    drive(nop, 0, 0, 0); #2 check("zero_fwd_a", fwd_a, 0); advance();
    repeat (3) step(nop);
    step(mk(1, 1, 0, 9, 1, 0, 0, 1));
    drive(mk(1, 1, 11, 0, 1, 0, 0, 0), 0, 0, 0); #2 check("zero_load_no_stall", stall, 0); advance();
    repeat (3) step(nop);

    // flush beats stall
    step(lw8);
    drive(add10, 1, 0, 0); #2
    check("flush_stall", stall, 0); check("flush_bubble", bubble, 1); check("flush_cnt", stall_cnt, 1);
    advance();
    repeat (3) step(nop);

    // hold for three cycles during a load-use stall
    step(lw8);
    repeat (3) begin
      drive(add10, 0, 1, 0); #2 check("hold_stall", stall, 1); check("hold_cnt", stall_cnt, 1); advance();
    end
    drive(add10, 0, 0, 0); #2 check("hold_rel_stall", stall, 1); check("hold_rel_cnt", stall_cnt, 1); advance();
    drive(add10, 0, 0, 0); #2 check("hold_after_stall", stall, 0); check("hold_after_cnt", stall_cnt, 2); advance();
    drive(nop, 0, 0, 0); #2 check("hold_fwd_a", fwd_a, 1); advance();

    // reset with EX/MEM/WB all valid and a load-use pending
    step(add3);
    step(mk(1, 1, 5, 3, 1, 3, 1, 0));
    step(lw8);
    drive(mk(1, 1, 12, 8, 1, 5, 1, 0), 0, 0, 1); advance();
    drive(mk(1, 1, 12, 8, 1, 5, 1, 0), 0, 0, 0); #2
    check("rst_fwd_a", fwd_a, 0); check("rst_fwd_b", fwd_b, 0); check("rst_stall", stall, 0);
    check("rst_bubble", bubble, 0); check("rst_cnt", stall_cnt, 0); check("rst_herr", hazard_err, 0);
    advance();

    // randomized traffic; a stalled ID instruction is usually re-presented as IF/ID would
    for (int i = 0; i < 4000; i++) begin
      if (cur_stall && $urandom_range(0, 3) != 0) begin
        rnd = cur_id;
      end else begin
        rnd = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      end
      step(rnd, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
    end

    repeat (2) @(negedge clk);
    #3;
    check("scoreboard_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
